score_pulse_gen: RTL and testbench

SCORE_PULSE_GEN -- requirements
Module: score_pulse_gen

---
 rtl/score_pkg.sv | 18 +
 rtl/score_tick_div.sv | 32 +++
 rtl/score_pulse_gen.sv | 132 +++++++++++++
 tb/tb_score_pulse_gen.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and constants for the score pulse generator.
package score_pkg;

  // Game state as seen by the scoring logic.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_OVER   = 2'd3
  } state_t;

  // Width of the points field that comes with an eat pulse.
  localparam int PTS_W = 4;

  // Default decay period: 1 s at 100 MHz.
  localparam int DECR_PERIOD_DEF = 100000000;

endpackage

// File: rtl/score_tick_div.sv
// Decay timer: counts 0..DECR_PERIOD-1 while run is high.
// tick fires combinationally during the terminal-count cycle, and the
// counter then wraps to 0. clr has priority over run and suppresses the tick.
module score_tick_div #(
  parameter int DECR_PERIOD = score_pkg::DECR_PERIOD_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (DECR_PERIOD > 1) ? $clog2(DECR_PERIOD) : 1;
  localparam logic [CNT_W-1:0] TC = CNT_W'(DECR_PERIOD - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = run && !clr && (cnt == TC);

  // Period counter: cleared, held, or advanced with wrap at terminal count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == TC) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/score_pulse_gen.sv
// Score pulse generator: turns eat/points events into one-cycle add pulses
// and, with hungry_mode, periodic decr pulses.
// Optional feature macro: SCORE_DECAY_EN (decay timer and decr output).
// Without it, decr and is_decreasing are tied low and hungry_mode is unused.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | after reset, waiting for start; eat ignored
// ST_RUN    | game active; pending drains as add pulses
// ST_PAUSED | scoring frozen; eat still accumulates
// ST_OVER   | game ended; pending cleared, waiting for start
module score_pulse_gen
  import score_pkg::*;
#(
  parameter int DECR_PERIOD = DECR_PERIOD_DEF,
  parameter int PEND_W      = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  input  logic              eat,
  input  logic [PTS_W-1:0]  points,
  input  logic              hungry_mode,
  input  logic              gameover,
  output logic              add,
  output logic              decr,
  output logic              is_decreasing,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int SUM_W = ((PEND_W > PTS_W) ? PEND_W : PTS_W) + 1;
  localparam logic [SUM_W-1:0] PEND_MAX = SUM_W'({PEND_W{1'b1}});

  state_t            state;
  state_t            state_nxt;
  logic              in_game;
  logic              start_acc;
  logic              eat_acc;
  logic              run_ok;
  logic              emit;
  logic              clip;
  logic              tick;
  logic [SUM_W-1:0]  sum;
  logic [PEND_W-1:0] pend_nxt;

  // Next-state decode; gameover takes priority over pause.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_RUN;
      ST_RUN: begin
        if (gameover)   state_nxt = ST_OVER;
        else if (pause) state_nxt = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (gameover)    state_nxt = ST_OVER;
        else if (!pause) state_nxt = ST_RUN;
      end
      ST_OVER:   if (start) state_nxt = ST_RUN;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign in_game   = (state == ST_RUN) || (state == ST_PAUSED);
  assign start_acc = start && ((state == ST_IDLE) || (state == ST_OVER));
  assign eat_acc   = eat && in_game;
  // Pulses are only launched when the game stays in RUN, so no registered
  // pulse can land in the first PAUSED or OVER cycle.
  assign run_ok    = (state == ST_RUN) && (state_nxt == ST_RUN);
  // A decay tick takes the slot; the add simply waits one cycle.
  assign emit      = run_ok && (pending != '0) && !tick;

  // Pending update: add new points, retire the emitted one, saturate.
  always_comb begin
    sum      = SUM_W'(pending) + (eat_acc ? SUM_W'(points) : '0) - SUM_W'(emit);
    clip     = (sum > PEND_MAX);
    pend_nxt = clip ? '1 : sum[PEND_W-1:0];
  end

`ifdef SCORE_DECAY_EN
  logic tmr_run;
  logic tmr_clr;

  assign tmr_run = run_ok && hungry_mode;
  assign tmr_clr = start_acc || !in_game || !hungry_mode || eat_acc;

  score_tick_div #(
    .DECR_PERIOD (DECR_PERIOD)
  ) u_tick_div (
    .clk   (clk),
    .reset (reset),
    .run   (tmr_run),
    .clr   (tmr_clr),
    .tick  (tick)
  );

  assign is_decreasing = (state == ST_RUN) && hungry_mode;
`else
  logic unused_cfg;

  assign tick          = 1'b0;
  assign is_decreasing = 1'b0;
  assign unused_cfg    = hungry_mode | (DECR_PERIOD == 0);
`endif

  // State, registered pulses, pending counter and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      add      <= 1'b0;
      decr     <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      add   <= emit;
      decr  <= tick;
      if (start_acc) begin
        pending  <= '0;
        overflow <= 1'b0;
      end else if (state_nxt == ST_OVER) begin
        pending <= '0;
      end else if (in_game) begin
        pending <= pend_nxt;
        if (clip) overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_score_pulse_gen.sv
// Directed bench for score_pulse_gen (DECR_PERIOD=10, PEND_W=4).
// Expected add/decr pulse cycles are queued when stimulus is driven and
// retired when the pulses are seen.
module tb_score_pulse_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       pause;
  logic       eat;
  logic [3:0] points;
  logic       hungry_mode;
  logic       gameover;
  logic       add;
  logic       decr;
  logic       is_decreasing;
  logic [3:0] pending;
  logic       overflow;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;
  int add_q[$];
  int decr_q[$];

  score_pulse_gen #(
    .DECR_PERIOD (10),
    .PEND_W      (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .pause         (pause),
    .eat           (eat),
    .points        (points),
    .hungry_mode   (hungry_mode),
    .gameover      (gameover),
    .add           (add),
    .decr          (decr),
    .is_decreasing (is_decreasing),
    .pending       (pending),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Retire expected pulses against what the DUT shows after this edge.
  task automatic monitor();
    check("add_decr_exclusive", {31'd0, add & decr}, 0);
    while (add_q.size() > 0 && add_q[0] < cyc) begin
      check("add_missed", add_q[0], cyc);
      void'(add_q.pop_front());
    end
    while (decr_q.size() > 0 && decr_q[0] < cyc) begin
      check("decr_missed", decr_q[0], cyc);
      void'(decr_q.pop_front());
    end
    if (add === 1'b1) begin
      if (add_q.size() == 0) check("add_unexpected", 1, 0);
      else check("add_cycle", cyc, add_q.pop_front());
    end
    if (decr === 1'b1) begin
      if (decr_q.size() == 0) check("decr_unexpected", 1, 0);
      else check("decr_cycle", cyc, decr_q.pop_front());
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_add_q_empty"}, add_q.size(), 0);
    check({tag, "_decr_q_empty"}, decr_q.size(), 0);
  endtask

  initial begin
    int t;
    reset = 1'b0; start = 1'b0; pause = 1'b0; eat = 1'b0;
    points = 4'd0; hungry_mode = 1'b0; gameover = 1'b0;

    // Reset state
    repeat (2) step();
    check("rst_add", {31'd0, add}, 0);
    check("rst_decr", {31'd0, decr}, 0);
    check("rst_pending", {28'd0, pending}, 0);
    check("rst_overflow", {31'd0, overflow}, 0);
    check("rst_is_decreasing", {31'd0, is_decreasing}, 0);
    reset = 1'b1;
    step();

    // Eat in IDLE is ignored
    eat = 1'b1; points = 4'd7;
    step();
    eat = 1'b0; points = 4'd0;
    check("idle_eat_pending", {28'd0, pending}, 0);
    step();

    // Start, eat 3 points: adds two cycles after eat is driven
    start = 1'b1;
    step();
    start = 1'b0;
    t = cyc;
    eat = 1'b1; points = 4'd3;
    for (int k = 2; k <= 4; k++) add_q.push_back(t + k);
    step();
    eat = 1'b0;
    check("eat3_pending_0", {28'd0, pending}, 3);
    for (int k = 1; k <= 3; k++) begin
      step();
      check("eat3_pending", {28'd0, pending}, 32'(3 - k));
    end
    step();
    check_empty("eat3");

`ifdef SCORE_DECAY_EN
    // Hunger decay: decr every 10 cycles
    hungry_mode = 1'b1;
    t = cyc;
    decr_q.push_back(t + 10);
    decr_q.push_back(t + 20);
    decr_q.push_back(t + 30);
    for (int k = 0; k < 30; k++) begin
      check("decay_is_decreasing", {31'd0, is_decreasing}, 1);
      step();
    end
    check_empty("decay");

    // Terminal count with pending=2: decr first, add deferred
    t = cyc;
    eat = 1'b1; points = 4'd11;
    for (int k = 2; k <= 10; k++) add_q.push_back(t + k);
    decr_q.push_back(t + 11);
    add_q.push_back(t + 12);
    add_q.push_back(t + 13);
    decr_q.push_back(t + 21);
    step();
    eat = 1'b0;
    repeat (9) step();
    check("conflict_pending_at_tc", {28'd0, pending}, 2);
    step();
    check("conflict_decr", {31'd0, decr}, 1);
    check("conflict_add_deferred", {31'd0, add}, 0);
    check("conflict_pending_held", {28'd0, pending}, 2);
    repeat (10) step();
    check_empty("conflict");
    repeat (7) step();
`else
    // Decay omitted: hungry_mode has no effect
    hungry_mode = 1'b1;
    for (int k = 0; k < 30; k++) begin
      check("nodecay_is_decreasing", {31'd0, is_decreasing}, 0);
      check("nodecay_decr", {31'd0, decr}, 0);
      step();
    end
    t = cyc;
    eat = 1'b1; points = 4'd11;
    for (int k = 2; k <= 12; k++) add_q.push_back(t + k);
    step();
    eat = 1'b0;
    repeat (12) step();
    check_empty("nodecay_drain");
`endif

    // Pause for 5 cycles (timer at 7 in the decay build), resume, then gameover
    pause = 1'b1;
    repeat (5) step();
    check("paused_is_decreasing", {31'd0, is_decreasing}, 0);
    pause = 1'b0;
`ifdef SCORE_DECAY_EN
    decr_q.push_back(cyc + 4);
`endif
    step();
    repeat (3) step();
    eat = 1'b1; points = 4'd5;
    step();
    eat = 1'b0;
    check("pre_over_pending", {28'd0, pending}, 5);
    gameover = 1'b1;
    step();
    check("over_pending", {28'd0, pending}, 0);
    check("over_is_decreasing", {31'd0, is_decreasing}, 0);
    repeat (5) step();
    gameover = 1'b0;
    check_empty("pause_over");

    // Eat in OVER is ignored
    eat = 1'b1; points = 4'd9;
    step();
    eat = 1'b0;
    check("over_eat_pending", {28'd0, pending}, 0);

    // Saturation: two 15-point eats back to back
    hungry_mode = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    t = cyc;
    eat = 1'b1; points = 4'd15;
    for (int k = 2; k <= 17; k++) add_q.push_back(t + k);
    step();
    check("sat_first_pending", {28'd0, pending}, 15);
    check("sat_first_overflow", {31'd0, overflow}, 0);
    step();
    eat = 1'b0;
    check("sat_pending", {28'd0, pending}, 15);
    check("sat_overflow", {31'd0, overflow}, 1);
    repeat (16) step();
    check("sat_drained", {28'd0, pending}, 0);
    check("sat_overflow_sticky", {31'd0, overflow}, 1);
    check_empty("sat");
    start = 1'b1;
    step();
    start = 1'b0;
    check("run_start_ignored_ovf", {31'd0, overflow}, 1);
    gameover = 1'b1;
    step();
    gameover = 1'b0;
    check("over_ovf_sticky", {31'd0, overflow}, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_ovf_clear", {31'd0, overflow}, 0);
    check("restart_pending", {28'd0, pending}, 0);

    // Reset mid-emission with pending=5
    t = cyc;
    eat = 1'b1; points = 4'd8;
    for (int k = 2; k <= 4; k++) add_q.push_back(t + k);
    step();
    eat = 1'b0;
    repeat (3) step();
    check("mid_pending", {28'd0, pending}, 5);
    check("mid_add", {31'd0, add}, 1);
    #1 reset = 1'b0;
    #1;
    check("async_rst_add", {31'd0, add}, 0);
    check("async_rst_pending", {28'd0, pending}, 0);
    check("async_rst_decr", {31'd0, decr}, 0);
    check("async_rst_is_decreasing", {31'd0, is_decreasing}, 0);
    repeat (2) step();
    reset = 1'b1;
    repeat (2) step();
    check("post_rst_pending", {28'd0, pending}, 0);
    eat = 1'b1; points = 4'd4;
    step();
    eat = 1'b0;
    check("post_rst_eat_ignored", {28'd0, pending}, 0);
    repeat (3) step();
    check_empty("reset");

    // Normal operation after restart
    start = 1'b1;
    step();
    start = 1'b0;
    t = cyc;
    eat = 1'b1; points = 4'd2;
    add_q.push_back(t + 2);
    add_q.push_back(t + 3);
    step();
    eat = 1'b0;
    check("restart_eat_pending", {28'd0, pending}, 2);
    repeat (3) step();
    check_empty("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
